// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: burst/response encodings, FSM states and burst address helpers for the banked AXI memory slave
package axi_mem_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BURST, R_DRAIN} r_state_t;
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] step, mask;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    return burst == BURST_FIXED ? a : burst == BURST_WRAP ? (a & ~mask) | ((a + step) & mask) : a + step;
  endfunction
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size, input logic [7:0] len, input logic [2:0] max_size);
    return burst == 2'b11 || size > max_size || (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_mem_bank.sv
// axi_mem_bank: single-port synchronous RAM with byte write enables and a read register held between reads
module axi_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic                     ACLK,
  input  logic [DATA_W/8-1:0]      we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < DATA_W/8; i++) if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/axi_banked_mem_slave.sv
// axi_banked_mem_slave: AXI4 slave over NBANKS SRAM banks with concurrent read/write engines and per-beat bank arbitration
module axi_banked_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int NBANKS     = 2,
  parameter int BANK_DEPTH = 2048
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int OFF = $clog2(DATA_W/8);
  localparam int DW  = $clog2(BANK_DEPTH);
  localparam int BB  = NBANKS > 1 ? $clog2(NBANKS) : 1;
  localparam logic [2:0] MAXS = 3'(OFF);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [ID_W-1:0] w_id, r_id;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [7:0] w_len, r_len, w_cnt, r_cnt;
  logic [2:0] w_size, r_size;
  logic [1:0] w_burst, r_burst;
  logic w_err, w_lerr, r_err, prio, w_req, r_req, clash, w_gnt, r_gnt;
  logic [BB-1:0] w_bank, r_bank, r_bank_q;
  logic [DW-1:0] w_row, r_row;
  logic [DATA_W-1:0] bank_rdata [NBANKS];
  assign w_row  = w_addr[OFF +: DW];
  assign r_row  = r_addr[OFF +: DW];
  assign w_bank = NBANKS > 1 ? w_addr[OFF+DW +: BB] : '0;
  assign r_bank = NBANKS > 1 ? r_addr[OFF+DW +: BB] : '0;
  // prio=0 favours the write on a same-bank clash; it flips to the loser after every clash
  assign w_req = w_state == W_DATA && WVALID;
  assign r_req = r_state == R_BURST && (!RVALID || RREADY);
  assign clash = w_req && r_req && w_bank == r_bank;
  assign w_gnt = w_req && !(clash && prio);
  assign r_gnt = r_req && !(clash && !prio);
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) prio <= 1'b0;
    else prio <= prio ^ clash;
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) w_state <= W_IDLE;
    else w_state <= w_next;
  always_comb
    w_next = w_state == W_IDLE ? (AWVALID ? W_DATA : W_IDLE) :
             w_state == W_DATA ? (w_gnt && w_cnt == w_len ? W_RESP : W_DATA) :
             (BREADY ? W_IDLE : W_RESP);
  always_comb begin
    AWREADY = w_state == W_IDLE;
    WREADY  = w_gnt;
    BVALID  = w_state == W_RESP;
    BID     = w_id;
    BRESP   = w_err || w_lerr ? RESP_SLVERR : RESP_OKAY;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_lerr  <= 1'b0;
    end else if (AWVALID && AWREADY) begin
      w_id    <= AWID;
      w_addr  <= AWADDR;
      w_len   <= AWLEN;
      w_size  <= AWSIZE;
      w_burst <= AWBURST;
      w_cnt   <= '0;
      w_err   <= burst_err(AWBURST, AWSIZE, AWLEN, MAXS);
      w_lerr  <= 1'b0;
    end else if (w_gnt) begin
      w_addr <= ADDR_W'(next_addr(64'(w_addr), w_size, w_len, w_burst));
      w_cnt  <= w_cnt + 8'd1;
      w_lerr <= w_lerr | (WLAST != (w_cnt == w_len));
    end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) r_state <= R_IDLE;
    else r_state <= r_next;
  always_comb
    r_next = r_state == R_IDLE ? (ARVALID ? R_BURST : R_IDLE) :
             r_state == R_BURST ? (r_gnt && r_cnt == r_len ? R_DRAIN : R_BURST) :
             (RVALID && RREADY ? R_IDLE : R_DRAIN);
  always_comb begin
    ARREADY = r_state == R_IDLE;
    RDATA   = RVALID && !RRESP[1] ? bank_rdata[r_bank_q] : '0;
  end
  // R outputs are registered at issue; the bank holds its read word until the next read to it
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_bank_q <= '0;
      RVALID   <= 1'b0;
      RID      <= '0;
      RRESP    <= '0;
      RLAST    <= 1'b0;
    end else if (ARVALID && ARREADY) begin
      r_id    <= ARID;
      r_addr  <= ARADDR;
      r_len   <= ARLEN;
      r_size  <= ARSIZE;
      r_burst <= ARBURST;
      r_cnt   <= '0;
      r_err   <= burst_err(ARBURST, ARSIZE, ARLEN, MAXS);
    end else if (r_gnt) begin
      r_addr   <= ADDR_W'(next_addr(64'(r_addr), r_size, r_len, r_burst));
      r_cnt    <= r_cnt + 8'd1;
      r_bank_q <= r_bank;
      RVALID   <= 1'b1;
      RID      <= r_id;
      RRESP    <= r_err ? RESP_SLVERR : RESP_OKAY;
      RLAST    <= r_cnt == r_len;
    end else if (RREADY) RVALID <= 1'b0;
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic w_hit, r_hit;
    assign w_hit = w_gnt && w_bank == BB'(b);
    assign r_hit = r_gnt && r_bank == BB'(b);
    axi_mem_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH)) u_bank (
      .ACLK(ACLK),
      .we(w_hit && !w_err ? WSTRB : '0),
      .re(r_hit),
      .addr(w_hit ? w_row : r_row),
      .wdata(WDATA),
      .rdata(bank_rdata[b])
    );
  end
endmodule

// File: tb/tb_axi_banked_mem_slave.sv
// tb_axi_banked_mem_slave: randomized bench checking the banked AXI slave against a flat word-array memory model
module tb_axi_banked_mem_slave;
  localparam int LIM = 2000;
  logic ACLK = 0, ARESETn = 0;
  logic [3:0] AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] mdl [4096];
  logic [31:0] last_wdata, last_rdata;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  axi_banked_mem_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;
  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // 4096 distinct words: 2 banks x 2048 words of 4 bytes; all higher address bits alias
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size, input int len, input logic [1:0] burst, input int i);
    longint step, span, base;
    step = longint'(1) << size;
    span = longint'(len + 1) * step;
    base = (longint'(start) / span) * span;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) return 32'(base + (longint'(start) - base + longint'(i) * step) % span);
    return 32'(longint'(start) + longint'(i) * step);
  endfunction

  function automatic bit is_err(input logic [1:0] burst, input int size, input int len);
    return burst == 2'b11 || size > 2 || (burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
  endfunction

  task automatic chk_reset(input string p);
    check({p, "_awready"}, AWREADY, 1);
    check({p, "_arready"}, ARREADY, 1);
    check({p, "_wready"}, WREADY, 0);
    check({p, "_bvalid"}, BVALID, 0);
    check({p, "_rvalid"}, RVALID, 0);
    check({p, "_bid"}, BID, 0);
    check({p, "_bresp"}, BRESP, 0);
    check({p, "_rid"}, RID, 0);
    check({p, "_rdata"}, RDATA, 0);
    check({p, "_rresp"}, RRESP, 0);
    check({p, "_rlast"}, RLAST, 0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                          input logic [1:0] burst, input logic [31:0] dval, input bit rnd_data,
                          input logic [3:0] strb, input bit rnd_strb, input bit gaps, input int abort_at);
    bit err;
    int g;
    err = is_err(burst, size, len);
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = burst; AWVALID = 1;
    g = 0;
    do @(negedge ACLK); while (!AWREADY && ++g < LIM);
    check("aw_tmo", g >= LIM, 0);
    @(posedge ACLK); #1 AWVALID = 0;
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(2) == 0) begin
        WVALID = 0;
        @(posedge ACLK); #1;
      end
      WDATA = rnd_data ? $urandom : dval;
      WSTRB = rnd_strb ? 4'($urandom) : strb;
      WLAST = i == len;
      WVALID = 1;
      if (i == abort_at) return;
      g = 0;
      do @(negedge ACLK); while (!WREADY && ++g < LIM);
      check("w_tmo", g >= LIM, 0);
      last_wdata = WDATA;
      if (!err)
        for (int j = 0; j < 4; j++)
          if (WSTRB[j]) mdl[widx(beat_addr(addr, size, len, burst, i))][j*8 +: 8] = WDATA[j*8 +: 8];
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0; BREADY = 1;
    g = 0;
    do @(negedge ACLK); while (!BVALID && ++g < LIM);
    check("b_tmo", g >= LIM, 0);
    check("bid", BID, id);
    check("bresp", BRESP, err ? 2'b10 : 2'b00);
    @(posedge ACLK); #1 BREADY = 0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                         input logic [1:0] burst, input bit gaps);
    bit err;
    int g, beat;
    err = is_err(burst, size, len);
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = burst; ARVALID = 1;
    g = 0;
    do @(negedge ACLK); while (!ARREADY && ++g < LIM);
    check("ar_tmo", g >= LIM, 0);
    @(posedge ACLK); #1 ARVALID = 0;
    beat = 0; g = 0;
    while (beat <= len && g < LIM) begin
      RREADY = gaps ? $urandom_range(3) != 0 : 1'b1;
      @(negedge ACLK);
      if (RVALID && RREADY) begin
        check("rdata", RDATA, err ? 32'd0 : mdl[widx(beat_addr(addr, size, len, burst, beat))]);
        check("rlast", RLAST, beat == len);
        check("rid", RID, id);
        check("rresp", RRESP, err ? 2'b10 : 2'b00);
        last_rdata = RDATA;
        beat++; g = 0;
      end else g++;
      @(posedge ACLK); #1;
    end
    check("r_tmo", g >= LIM, 0);
    RREADY = 0;
  endtask

  initial begin
    int t0, tg;
    logic prev;
    logic [1:0] bu;
    int sz, ln;
    logic [31:0] ad;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY} = '0;
    repeat (3) @(posedge ACLK);
    #1 chk_reset("rst");
    ARESETn = 1;
    // fill the whole memory so every later read has a defined model value (also covers LEN=255)
    for (int k = 0; k < 16; k++) do_write(4'(k), 32'(k * 1024), 255, 2, 2'b01, 0, 1, 4'hF, 0, 0, -1);
    do_write(4'h1, 0, 127, 2, 2'b01, 0, 1, 4'hF, 0, 0, -1);
    do_read(4'h1, 0, 127, 2, 2'b01, 0);
    do_write(4'h2, 32'h8, 3, 2, 2'b10, 0, 1, 4'hF, 0, 0, -1);
    do_read(4'h2, 32'h8, 3, 2, 2'b10, 0);
    do_read(4'h2, 32'h0, 3, 2, 2'b01, 0);
    t0 = cyc;
    fork
      do_write(4'h3, 32'h0, 127, 2, 2'b01, 0, 1, 4'hF, 0, 0, -1);
      do_read(4'h4, 32'h2000, 127, 2, 2'b01, 0);
    join
    check("par_cycles_le_135", (cyc - t0) <= 135, 1);
    fork
      do_write(4'h5, 32'h400, 31, 2, 2'b01, 0, 1, 4'hF, 0, 0, -1);
      do_read(4'h6, 32'h800, 31, 2, 2'b01, 0);
      begin
        tg = 0;
        repeat (3) @(negedge ACLK);
        prev = WREADY;
        for (int k = 0; k < 8; k++) begin
          @(negedge ACLK);
          tg += int'(WREADY != prev);
          prev = WREADY;
        end
        check("alt_toggles", tg, 8);
      end
    join
    do_write(4'h7, 32'h100, 0, 2, 2'b01, 32'hAAAA5555, 0, 4'hF, 0, 0, -1);
    do_write(4'h7, 32'h100, 0, 2, 2'b01, 0, 1, 4'b1100, 0, 0, -1);
    do_read(4'h7, 32'h100, 0, 2, 2'b01, 0);
    check("strb_lo", last_rdata[15:0], 16'h5555);
    check("strb_hi", last_rdata[31:16], last_wdata[31:16]);
    do_write(4'h8, 32'h100, 3, 2, 2'b11, 0, 1, 4'hF, 0, 0, -1);
    do_write(4'h9, 32'h100, 2, 2, 2'b10, 0, 1, 4'hF, 0, 0, -1);
    do_write(4'hA, 32'h100, 0, 2, 2'b10, 0, 1, 4'hF, 0, 0, -1);
    do_read(4'h8, 32'h100, 3, 2, 2'b01, 0);
    do_read(4'h9, 32'h100, 1, 3, 2'b01, 0);
    do_read(4'hA, 32'h100, 0, 2, 2'b10, 0);
    do_read(4'hB, 32'h100, 1, 2, 2'b11, 0);
    do_write(4'hC, 32'h1000, 127, 2, 2'b01, 0, 1, 4'hF, 0, 0, 40);
    #2 check("pre_rst_wready", WREADY, 1);
    ARESETn = 0;
    #1 chk_reset("async_rst");
    WVALID = 0; WLAST = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    do_read(4'hC, 32'h1000, 127, 2, 2'b01, 0);
    do_write(4'hD, 32'h1000, 15, 2, 2'b01, 0, 1, 4'hF, 0, 0, -1);
    do_read(4'hD, 32'h1000, 15, 2, 2'b01, 0);
    for (int it = 0; it < 24; it++) begin
      bu = 2'($urandom_range(2));
      sz = $urandom_range(2);
      ln = bu == 2'b10 ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(20);
      ad = ($urandom & 32'h7FFF_FFFF) & ~((32'd1 << sz) - 32'd1);
      do_write(4'($urandom), ad, ln, sz, bu, 0, 1, 4'hF, 1, 1, -1);
      do_read(4'($urandom), ad, ln, sz, bu, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_banked_mem_slave.md
Name: axi_banked_mem_slave

Overview:
Parametrised AXI4 slave that maps a multi-bank on-chip SRAM into a single address window. It supports FIXED, INCR and WRAP bursts, byte strobes and narrow transfers. Independent read and write engines run concurrently when they target different banks and are arbitrated per beat when they collide. It is the next-generation AXI-to-memory endpoint and sits behind the interconnect as a leaf slave.

Parameters:
DATA_W, 32, data bus width in bits (32/64/128)
ADDR_W, 32, AXI address width
ID_W, 4, AXI ID width
NBANKS, 2, number of SRAM banks (power of 2, >=1)
BANK_DEPTH, 2048, words per bank (power of 2)

Ports:
ACLK  in  1  clock
ARESETn  in  1  async active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address
AWVALID in 1; AWREADY out 1  AW handshake
WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data
WVALID in 1; WREADY out 1  W handshake
BID/BRESP  out  ID_W/2  write response
BVALID out 1; BREADY in 1  B handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address
ARVALID in 1; ARREADY out 1  AR handshake
RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data
RVALID out 1; RREADY in 1  R handshake

Behaviour:
- Clock ACLK; reset ARESETn, asynchronous, active-low. On reset all VALID/READY outputs are 0 except AWREADY=ARREADY=1. BID, BRESP, RID, RDATA, RRESP and RLAST are 0. Both FSMs go to IDLE. Memory contents are not cleared.
- Address map: word = addr >> log2(DATA_W/8). Bank = word[log2(BANK_DEPTH) +: log2(NBANKS)]. Upper address bits alias.
- Beat address: FIXED keeps the start address. INCR adds 2^SIZE per beat. WRAP wraps within a (LEN+1)<<SIZE aligned boundary.
- Errors giving SLVERR (2'b10) for the whole burst:
  - BURST=2'b11.
  - SIZE > log2(DATA_W/8).
  - WRAP with LEN not in {1,3,7,15}.
  On an errored write, strobes are forced to 0 (no memory change). On an errored read, RDATA=0.
- Write FSM has three states:
  - W_IDLE: AWREADY=1. An AW handshake latches ID/addr/len/size/burst and moves to W_DATA with AWREADY=0.
  - W_DATA: WREADY=1 when the write holds the bank grant. Each W handshake writes the bytes enabled by WSTRB, then advances addr and the beat count. The beat where count==LEN moves to W_RESP. WLAST is ignored for control; a WLAST mismatch with the count gives SLVERR.
  - W_RESP: BVALID=1, BID=latched ID. The BREADY handshake returns to W_IDLE, with AWREADY=1 on the next cycle.
- Read FSM has three states:
  - R_IDLE: ARREADY=1. An AR handshake latches the fields and moves to R_BURST.
  - R_BURST: a beat issues to RAM when the read holds the bank grant and (!RVALID || RREADY). RAM latency is 1 cycle. RVALID is set the cycle after issue with RID, RRESP and RLAST (RLAST=1 on beat LEN).
  - R_DRAIN: after the last issue, wait for the final R handshake, then return to R_IDLE.
- Sustained throughput is 1 beat/cycle per channel when RREADY and WVALID are held high.
- Bank arbitration runs every cycle:
  - Write and read requests to different banks are both granted.
  - Same-bank requests use round-robin with a 1-bit priority that flips to the loser after each conflict. On the first conflict after reset, write wins.
  - An ungranted write holds WREADY=0. An ungranted read holds issue.
- WRAP with LEN=0 is not defined by AXI; treat it as an error.
- LEN=255 is legal (256 beats); beat counters are 8 bits.
- Simultaneous AW and AR in the same cycle are both accepted.
- Reset mid-burst abandons the burst. Partial writes already committed stay in memory, and no B or R is issued afterwards.

Decomposition:
- Package axi_mem_pkg holds:
  - Burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The next_addr() function (FIXED/INCR/WRAP).
  - The burst_err() check function.
- One sub-module, axi_mem_bank: a single-port synchronous RAM with per-byte write enables and 1-cycle read, instantiated NBANKS times in a generate loop.
- Arbitration and both FSMs stay in the top level.

Test Plan:
1. INCR, AWLEN=127, SIZE=2, addr 0x0, random WDATA, WSTRB=4'hF; then AR same → 128 R beats match written data. RLAST only on beat 127. BRESP=RRESP=OKAY.
2. WRAP, LEN=3, SIZE=2, addr 0x8 → writes land at 0x8, 0xC, 0x0, 0x4. A WRAP read from 0x8 returns them in that order.
3. Write bank0 (addr 0x0) and read bank1 (addr 0x2000), both LEN=127, issued in the same cycle → both complete within 135 cycles with no stalls.
4. Write and read both in bank0 → per-beat conflict alternates grants (W,R,W,R...). Both bursts finish with correct data.
5. WSTRB=4'b1100 over a preloaded 0xAAAA5555 → reads 0x{new[31:16]}5555. AWBURST=2'b11 → BRESP=SLVERR and memory unchanged.
6. Assert ARESETn=0 at beat 40 of a 128-beat write → all outputs return to reset values asynchronously. A new burst after release completes OKAY.
